// File: rtl/bram_if_pkg.sv
// Shared BRAM widths, controller state encoding and
// command bundle for the burst controller slice.
package bram_if_pkg;

  localparam int DW_C = 18;
  localparam int AW_C = 12;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD       = 2'd1,
    S_RD_DRAIN = 2'd2,
    S_WR       = 2'd3
  } state_t;

  typedef struct packed {
    logic            write;
    logic [AW_C-1:0] addr;
    logic [AW_C-1:0] len;
  } bram_cmd_t;

endpackage

// File: rtl/bram_rd_stage.sv
// One-entry read-data output register with valid/ready
// and a load-enable driven by the BRAM issue logic.
module bram_rd_stage #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_slot_free
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_slot_free = !r_valid || i_ready;

endmodule

// File: rtl/bram_burst_ctrl.sv
// Burst read/write initiator and sole master of the
// single-port 4096 x 18 BRAM data store.
module bram_burst_ctrl
  import bram_if_pkg::*;
#(
  parameter int DW = DW_C,
  parameter int AW = AW_C
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WRITE,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [AW-1:0] CMD_LEN,
  input  logic          WD_VALID,
  output logic          WD_READY,
  input  logic [DW-1:0] WD_DATA,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [DW-1:0] RD_DATA,
  output logic          DONE,
  output logic          BUSY,
  output logic          BRAM_EN,
  output logic          BRAM_READ,
  output logic          BRAM_WRITE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DIN,
  input  logic [DW-1:0] BRAM_DOUT
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_rem;
  logic          r_done;

  bram_cmd_t     w_cmd;
  logic          w_cmd_hs;
  logic          w_slot_free;
  logic          w_rd;
  logic          w_wr;
  logic          w_last;

  assign w_cmd = '{
    write: CMD_WRITE,
    addr:  CMD_ADDR,
    len:   CMD_LEN
  };

  assign CMD_READY = (r_state == S_IDLE) && !RST;
  assign WD_READY  = (r_state == S_WR) && !RST;
  assign w_cmd_hs  = CMD_READY && CMD_VALID;

  assign w_wr   = WD_READY && WD_VALID;
  assign w_rd   = (r_state == S_RD) && w_slot_free && !RST;
  assign w_last = (r_rem == '0);

  assign BRAM_EN    = w_rd || w_wr;
  assign BRAM_READ  = w_rd;
  assign BRAM_WRITE = w_wr;
  assign BRAM_ADDR  = BRAM_EN ? r_addr : '0;
  assign BRAM_DIN   = w_wr ? WD_DATA : '0;

  assign BUSY = (r_state != S_IDLE);
  assign DONE = r_done;

  bram_rd_stage #(.DW(DW)) u_rd_stage (
    .clk         (CLK),
    .rst         (RST),
    .i_load      (w_rd),
    .i_data      (BRAM_DOUT),
    .i_ready     (RD_READY),
    .o_valid     (RD_VALID),
    .o_data      (RD_DATA),
    .o_slot_free (w_slot_free)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_addr  <= w_cmd.addr;
            r_rem   <= w_cmd.len;
            r_state <= w_cmd.write ? S_WR : S_RD;
          end
        end
        S_RD: begin
          if (w_rd) begin
            r_addr <= r_addr + 1'b1;
            if (w_last) begin
              r_state <= S_RD_DRAIN;
            end else begin
              r_rem <= r_rem - 1'b1;
            end
          end
        end
        S_RD_DRAIN: begin
          if (RD_VALID && RD_READY) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WR: begin
          if (w_wr) begin
            r_addr <= r_addr + 1'b1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_rem <= r_rem - 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bram_burst_ctrl.md
# bram_burst_ctrl

Initiator for the single-port BRAM data store. It accepts burst read/write commands from a client over a valid/ready command channel and drives the BRAM port one word per cycle. Write data arrives on a valid/ready stream, and read data leaves on a backpressured valid/ready stream. It sits between the clause/watch-list fetch logic and the 4096 x 18 BRAM, and is the only master of that port.

## Interface
Parameters:
- DW, 18, data word width (matches BRAM data bus)
- AW, 12, address width (4096 words)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when both high
- CMD_WRITE  in  1  1 = burst write, 0 = burst read
- CMD_ADDR  in  AW  start word address
- CMD_LEN  in  AW  word count minus one (0 = 1 word, 4095 = 4096 words)
- WD_VALID / WD_READY / WD_DATA  in / out / in(DW)  write-data stream
- RD_VALID / RD_READY / RD_DATA  out / in / out(DW)  read-data stream
- DONE  out  1  one-cycle pulse on burst completion
- BUSY  out  1  high whenever state is not IDLE
- BRAM_EN, BRAM_READ, BRAM_WRITE  out  1 each  BRAM strobes
- BRAM_ADDR  out  AW  BRAM address
- BRAM_DIN  out  DW  BRAM write data
- BRAM_DOUT  in  DW  BRAM read data; combinational from BRAM_ADDR when BRAM_EN & BRAM_READ

## Operation
- FSM states: IDLE, RD, RD_DRAIN, WR.
- IDLE:
  - CMD_READY = 1.
  - On a command handshake, latch cur_addr = CMD_ADDR and remaining = CMD_LEN.
  - Next state is WR if CMD_WRITE, else RD.
- RD:
  - Issue a read whenever the output slot is free, i.e. !RD_VALID | RD_READY.
  - Issue means BRAM_EN = BRAM_READ = 1 and BRAM_ADDR = cur_addr.
  - At the clock edge: RD_DATA <= BRAM_DOUT, RD_VALID <= 1, cur_addr++, remaining--.
  - The issue for remaining == 0 moves the FSM to RD_DRAIN.
- RD_DRAIN:
  - No BRAM access.
  - On RD_VALID & RD_READY: RD_VALID <= 0, DONE <= 1, next state IDLE.
- WR:
  - WD_READY = 1.
  - On WD handshake: BRAM_EN = BRAM_WRITE = 1, BRAM_ADDR = cur_addr, BRAM_DIN = WD_DATA, all combinational in the same cycle. The BRAM commits on that edge.
  - Then cur_addr++, remaining--.
  - The handshake with remaining == 0 sets DONE <= 1 and moves to IDLE.
- Outside IDLE: CMD_READY = 0. Outside WR: WD_READY = 0.
- RD_VALID holds and RD_DATA stays stable until the handshake (AXI-style; RD_VALID never drops without RD_READY).
- BRAM_READ and BRAM_WRITE are never high together. Either implies BRAM_EN.
- No access: BRAM_EN/READ/WRITE = 0, BRAM_ADDR = 0, BRAM_DIN = 0.
- Address arithmetic: cur_addr increments modulo 2^AW. Start 4094 with LEN 3 accesses 4094, 4095, 0, 1.
- remaining is an AW-bit down-counter. Its 0 test is the last-word marker, so there is no underflow.

## Timing
- Reset values: state IDLE, RD_VALID 0, RD_DATA 0, DONE 0, cur_addr 0, remaining 0. After the reset edge, BUSY = 0 and CMD_READY = 1.
- While RST is high, BRAM_EN = 0, CMD_READY = 0, WD_READY = 0.
- Reset mid-burst aborts the burst: no DONE, buffered read word discarded, partial writes stay in BRAM.
- Command accepted at edge T: first BRAM access can occur in cycle T+1.
- Read latency: access in cycle N gives RD_VALID high in cycle N+1.
- With RD_READY held high, sustained throughput is 1 word/cycle. An N-word read gives RD_VALID in cycles T+2..T+N+1, and DONE in cycle T+N+2.
- Write: with WD_VALID held high, writes occur in cycles T+1..T+N, and DONE is in cycle T+N+1.
- DONE is high in the first IDLE cycle. A new command may be accepted in that same cycle.
- RD_READY low stalls BRAM issue. No word is read twice or skipped.

## Structure
- Shared package bram_if_pkg:
  - DW/AW constants, shared with the BRAM.
  - state_t enum.
  - bram_cmd_t struct {write, addr, len}.
- One sub-module: bram_rd_stage, a one-entry output register with valid/ready and a load-enable.
  - Exposes slot_free = !RD_VALID | RD_READY to the FSM.
- FSM, counters and BRAM drive logic live in the top module.

## Test plan
- Reset, then 4-word write at addr 0x010 (data 0x00001..0x00004), then 4-word read of 0x010 with RD_READY = 1 -> RD_DATA 1,2,3,4 in consecutive cycles; DONE once per burst at the stated cycles.
- Wrap: write LEN 3 at 0xFFE, data A,B,C,D -> BRAM words 0xFFE,0xFFF,0x000,0x001 = A,B,C,D; read back matches.
- Backpressure: 3-word read with RD_READY toggling 1,0,0,1,0,1 -> each word presented exactly once, RD_DATA stable while stalled, BRAM_EN low during stalls.
- Write stream gaps: WD_VALID low for 2 cycles mid-burst -> BRAM_EN low in those cycles, address does not advance, DONE after the final word.
- Reset mid-read, after 2 of 5 words -> RD_VALID 0 next cycle, no DONE, BUSY 0, CMD_READY 1; a new 1-word read then works.
- Back-to-back: a new command presented during the DONE cycle -> accepted in that cycle. Protocol assertions hold throughout: READ & WRITE never both high, RD_VALID never drops unacknowledged.
